// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word line fill, round-robin replacement and flush.
// Optional feature: define ICACHE_PERF_EN to add the hit_count/miss_count performance counters.
module icache_assoc #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmem_busy,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF   = $clog2(BLOCK_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - OFF - IDX;
  localparam int CNT_W = (OFF > 0) ? OFF : 1;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_WAY  = PTR_W'(WAYS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic             valid_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [PTR_W-1:0] ptr_q   [SETS];

  logic [TAG_W-1:0] fill_tag_q;
  logic [IDX-1:0]   fill_set_q;
  logic [CNT_W-1:0] fill_cnt_q;
  logic [PTR_W-1:0] victim_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   req_set;
  logic [CNT_W-1:0] req_word;
  logic             match;
  logic [31:0]      match_word;
  logic             access, miss, fill_accept, fill_done;
  logic [31:0]      fill_base;

  assign req_word = CNT_W'(imemaddr >> 2) & LAST_WORD;
  assign req_set  = IDX'(imemaddr >> (2 + OFF));
  assign req_tag  = TAG_W'(imemaddr >> (2 + OFF + IDX));

  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    match      = 1'b0;
    match_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_set] && (tag_q[w][req_set] == req_tag)) begin
        match      = 1'b1;
        match_word = data_q[w][req_set][req_word];
      end
    end
  end

  assign access      = imemREN & ~dmem_busy & ~flush & (state_q == IDLE);
  assign miss        = access & ~match;
  assign fill_accept = (state_q == FILL) & ~iwait & ~flush;
  assign fill_done   = fill_accept & (fill_cnt_q == LAST_WORD);
  assign fill_base   = 32'({fill_tag_q, fill_set_q}) << (2 + OFF);

  always_comb begin
    state_d  = state_q;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: begin
        ihit = access & match;
        if (ihit) imemload = match_word;
        if (miss) state_d = FILL;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_base | (32'(fill_cnt_q) << 2);
        // Flush aborts the fill even when the final word arrives in the same cycle.
        if (flush || fill_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      fill_tag_q <= '0;
      fill_set_q <= '0;
      fill_cnt_q <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (miss) begin
        fill_tag_q                    <= req_tag;
        fill_set_q                    <= req_set;
        fill_cnt_q                    <= '0;
        victim_q                      <= ptr_q[req_set];
        // The victim is invalid for the whole fill so partial lines never hit.
        valid_q[ptr_q[req_set]][req_set] <= 1'b0;
      end
      if (fill_accept) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (fill_done) begin
        valid_q[victim_q][fill_set_q] <= 1'b1;
        ptr_q[fill_set_q]             <= (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
      end
      if (flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge CLK) begin
    if (miss) tag_q[ptr_q[req_set]][req_set] <= req_tag;
    if (fill_accept) data_q[victim_q][fill_set_q][fill_cnt_q] <= iload;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios followed by randomized accesses,
// compared against a residency model that tracks cached line numbers per set.
module tb_icache_assoc;

  localparam int SETS        = 8;
  localparam int WAYS        = 2;
  localparam int BLOCK_WORDS = 2;
  localparam int LINE_BYTES  = 4 * BLOCK_WORDS;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmem_busy;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: which memory lines each set holds, and the next way to replace.
  logic [31:0] m_line  [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_ptr   [SETS];
  int          m_hits;
  int          m_misses;

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmem_busy (dmem_busy),
    .flush     (flush),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hAAAA0000 + (a >> 2) - 32'd15;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    logic [31:0] line;
    int          s;
    line = a / LINE_BYTES;
    s    = int'(line % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == line) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One fetch of addr; on a miss, serves the line fill with random stalls and random
  // imemREN/imemaddr/dmem_busy noise, then checks the follow-up cycle.
  task automatic access(input logic [31:0] addr, input bit busy, input bit drop_ren);
    logic [31:0] line, base, exp_a;
    int          s, victim, stalls;
    bit          hit;
    line = addr / LINE_BYTES;
    base = line * LINE_BYTES;
    s    = int'(line % SETS);
    @(negedge CLK);
    imemREN   = 1'b1;
    imemaddr  = addr;
    dmem_busy = busy;
    flush     = 1'b0;
    iwait     = 1'b1;
    iload     = '0;
    #1;
    hit = model_hit(addr) && !busy;
    check_bit($sformatf("req_iren@%08h", addr), iREN, 1'b0);
    check_bit($sformatf("req_ihit@%08h", addr), ihit, hit);
    check($sformatf("req_load@%08h", addr), imemload, hit ? mem_data(addr) : 32'd0);
    if (busy) return;
    if (hit) begin
      m_hits++;
      return;
    end
    m_misses++;
    victim = m_ptr[s];
    m_valid[s][victim] = 1'b0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      exp_a  = base + 32'(4 * w);
      stalls = int'($urandom_range(0, 2));
      for (int k = 0; k <= stalls; k++) begin
        @(negedge CLK);
        imemREN   = drop_ren ? (w == 0) : 1'($urandom_range(0, 1));
        imemaddr  = $urandom;
        dmem_busy = 1'($urandom_range(0, 1));
        iwait     = (k < stalls);
        iload     = (k < stalls) ? $urandom : mem_data(exp_a);
        #1;
        check_bit($sformatf("fill_iren@%08h", exp_a), iREN, 1'b1);
        check($sformatf("fill_iaddr@%08h", exp_a), iaddr, exp_a);
        check_bit($sformatf("fill_ihit@%08h", exp_a), ihit, 1'b0);
      end
    end
    m_line[s][victim]  = line;
    m_valid[s][victim] = 1'b1;
    m_ptr[s]           = (victim + 1) % WAYS;
    @(negedge CLK);
    iwait     = 1'b1;
    dmem_busy = 1'b0;
    imemaddr  = addr;
    imemREN   = !drop_ren;
    #1;
    check_bit($sformatf("post_iren@%08h", addr), iREN, 1'b0);
    check_bit($sformatf("post_ihit@%08h", addr), ihit, !drop_ren);
    check($sformatf("post_load@%08h", addr), imemload, drop_ren ? 32'd0 : mem_data(addr));
    if (!drop_ren) m_hits++;
  endtask

`ifdef ICACHE_PERF_EN
  task automatic check_perf(input string tag);
    @(negedge CLK);
    imemREN = 1'b0;
    flush   = 1'b0;
    #1;
    check({tag, "_hits"}, hit_count, 32'(m_hits));
    check({tag, "_misses"}, miss_count, 32'(m_misses));
  endtask
`endif

  initial begin
    logic [31:0] a;
    int          victim;

    // Reset state, with a fetch request pending.
    nRST      = 1'b0;
    imemREN   = 1'b1;
    imemaddr  = 32'h40;
    dmem_busy = 1'b0;
    flush     = 1'b0;
    iwait     = 1'b1;
    iload     = '0;
    model_reset();
    #12;
    check_bit("rst_ihit", ihit, 1'b0);
    check("rst_imemload", imemload, 32'd0);
    check_bit("rst_iren", iREN, 1'b0);
    check("rst_iaddr", iaddr, 32'd0);
    @(negedge CLK);
    imemREN = 1'b0;
    nRST    = 1'b1;

    // Cold miss then hits on both words of the line.
    access(32'h40, 1'b0, 1'b0);
    access(32'h44, 1'b0, 1'b0);

    // Two ways of set 0, then round-robin eviction.
    access(32'h80, 1'b0, 1'b0);
    access(32'h40, 1'b0, 1'b0);
    access(32'h80, 1'b0, 1'b0);
    access(32'hC0, 1'b0, 1'b0);
    access(32'h80, 1'b0, 1'b0);
    access(32'h40, 1'b0, 1'b0);

    // dmem_busy blocks both hits and misses.
    access(32'h40, 1'b1, 1'b0);
    access(32'h300, 1'b1, 1'b0);
    access(32'h40, 1'b0, 1'b0);

    // Flush in IDLE, then flush colliding with the final fill word.
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    flush    = 1'b1;
    iwait    = 1'b1;
    #1;
    check_bit("flush_idle_ihit", ihit, 1'b0);
    check_bit("flush_idle_iren", iREN, 1'b0);
    model_flush();
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check_bit("abort_miss_ihit", ihit, 1'b0);
    m_misses++;
    victim = m_ptr[0];
    m_valid[0][victim] = 1'b0;
    @(negedge CLK);
    iwait = 1'b0;
    iload = mem_data(32'h40);
    #1;
    check_bit("abort_w0_iren", iREN, 1'b1);
    check("abort_w0_iaddr", iaddr, 32'h40);
    @(negedge CLK);
    iload = mem_data(32'h44);
    flush = 1'b1;
    #1;
    check("abort_w1_iaddr", iaddr, 32'h44);
    model_flush();
    @(negedge CLK);
    flush   = 1'b0;
    iwait   = 1'b1;
    imemREN = 1'b0;
    #1;
    check_bit("abort_idle_iren", iREN, 1'b0);
    check("abort_idle_iaddr", iaddr, 32'd0);
    access(32'h40, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a fill.
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    #1;
    check_bit("rstfill_miss_ihit", ihit, 1'b0);
    @(negedge CLK);
    iwait = 1'b0;
    iload = mem_data(32'h200);
    #1;
    check("rstfill_w0_iaddr", iaddr, 32'h200);
    @(negedge CLK);
    iwait = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check_bit("rstfill_ihit", ihit, 1'b0);
    check("rstfill_imemload", imemload, 32'd0);
    check_bit("rstfill_iren", iREN, 1'b0);
    check("rstfill_iaddr", iaddr, 32'd0);
    model_reset();
    @(negedge CLK);
    imemREN = 1'b0;
    nRST    = 1'b1;

    // imemREN dropped after the first fill word: the line still completes.
    access(32'h40, 1'b0, 1'b1);
    access(32'h40, 1'b0, 1'b0);
`ifdef ICACHE_PERF_EN
    check_perf("perf_drop");
`endif
    access(32'h80, 1'b0, 1'b0);
    access(32'hC0, 1'b0, 1'b0);
    access(32'h200, 1'b0, 1'b0);

    // Randomized traffic over a small address pool to force hits, conflicts and evictions.
    for (int i = 0; i < 200; i++) begin
      a = 32'(int'($urandom_range(0, 3)) * SETS * LINE_BYTES
            + int'($urandom_range(0, SETS - 1)) * LINE_BYTES
            + int'($urandom_range(0, BLOCK_WORDS - 1)) * 4);
      if ($urandom_range(0, 15) == 0) begin
        @(negedge CLK);
        imemREN   = 1'($urandom_range(0, 1));
        imemaddr  = a;
        dmem_busy = 1'b0;
        flush     = 1'b1;
        iwait     = 1'b1;
        #1;
        check_bit("rand_flush_ihit", ihit, 1'b0);
        check_bit("rand_flush_iren", iREN, 1'b0);
        model_flush();
      end
      access(a, ($urandom_range(0, 7) == 0), 1'b0);
    end
`ifdef ICACHE_PERF_EN
    check_perf("perf_final");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
